// File: rtl/wb_regfile_pkg.sv
// Shared processor definitions used by the write-back stage and the pipeline registers.
package wb_regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    localparam logic [REG_ADDR_W-1:0] X0_IDX = '0;

    // A write only commits when enabled and not aimed at the hardwired zero register.
    function automatic logic commitsWrite(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != X0_IDX);
    endfunction

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Write-back data selection between load data and the ALU result.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = wb_regfile_pkg::XLEN
) (
    input  logic [XLEN-1:0] read_data_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            mem_to_reg_i,
    output logic [XLEN-1:0] wb_data_o
);

    assign wb_data_o = mem_to_reg_i ? read_data_i : alu_result_i;

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with write-back bypass, x0 hardwiring and a commit counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       read_data_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic [CNT_W-1:0]      wb_count
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [XLEN-1:0]  muxData;
    logic             writeEn;

    wb_mux #(.XLEN(XLEN)) u_wb_mux (
        .read_data_i  (read_data_in),
        .alu_result_i (alu_result_in),
        .mem_to_reg_i (mem_to_reg_in),
        .wb_data_o    (muxData)
    );

    // Reset also masks the enable so nothing can commit or bypass while it is asserted.
    assign writeEn  = rst && commitsWrite(reg_write_in, rd_in);
    assign wb_we    = writeEn;
    assign wb_rd    = rd_in;
    assign wb_data  = muxData;
    assign wb_count = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (writeEn) begin
            regs_q[rd_in] <= muxData;
        end
    end

    always_comb begin
        count_d = count_q;
        if (writeEn) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Same-cycle hazard: the value being written this edge wins over the stale array entry.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rst) begin
            if (rs1_addr != X0_IDX) begin
                rs1_data = (writeEn && rs1_addr == rd_in) ? muxData : regs_q[rs1_addr];
            end
            if (rs2_addr != X0_IDX) begin
                rs2_data = (writeEn && rs2_addr == rd_in) ? muxData : regs_q[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vectors, corner sequences and random traffic.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] read_data_in, alu_result_in;
    logic [4:0]  rd_in, rs1_addr, rs2_addr;
    logic        reg_write_in, mem_to_reg_in;
    logic [31:0] rs1_data, rs2_data, wb_data, wb_count;
    logic        wb_we;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .read_data_in  (read_data_in),
        .alu_result_in (alu_result_in),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_we         (wb_we),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .wb_count      (wb_count)
    );

    int vecCount  = 0;
    int missCount = 0;

    logic [31:0] mRegs [32];
    logic [31:0] mCount;

    typedef struct {
        logic [31:0] readData;
        logic [31:0] aluResult;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memToReg;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] expRs1;
        logic [31:0] expRs2;
        logic        expWe;
        logic [31:0] expData;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] rdat, input logic [31:0] alu, input logic [4:0] rd,
                                 input logic rw, input logic m2r, input logic [4:0] a1, input logic [4:0] a2);
        read_data_in  = rdat;
        alu_result_in = alu;
        rd_in         = rd;
        reg_write_in  = rw;
        mem_to_reg_in = m2r;
        rs1_addr      = a1;
        rs2_addr      = a2;
        #2;
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
        mCount = 32'h0;
    endfunction

    function automatic logic [31:0] modelWbData();
        return mem_to_reg_in ? read_data_in : alu_result_in;
    endfunction

    function automatic logic modelWe();
        return rst && reg_write_in && (rd_in != 5'd0);
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        if (!rst || a == 5'd0) return 32'h0;
        if (modelWe() && a == rd_in) return modelWbData();
        return mRegs[a];
    endfunction

    // Commit the presented write into the model, then cross the rising edge.
    task automatic tickEdge();
        if (modelWe()) begin
            mRegs[rd_in] = modelWbData();
            mCount       = mCount + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'hCAFEBABE, 32'hDEADBEEF, 5'd12, 1'b1, 1'b1, 5'd12, 5'd0,
                    32'hCAFEBABE, 32'h0, 1'b1, 32'hCAFEBABE, 32'd0};
        vecs[1] = '{32'h0, 32'h0, 5'd12, 1'b0, 1'b0, 5'd12, 5'd12,
                    32'hCAFEBABE, 32'hCAFEBABE, 1'b0, 32'h0, 32'd1};
        vecs[2] = '{32'h0, 32'h00000042, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5,
                    32'h00000042, 32'h00000042, 1'b1, 32'h00000042, 32'd1};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b1, 1'b1, 5'd0, 5'd5,
                    32'h0, 32'h00000042, 1'b0, 32'hFFFFFFFF, 32'd2};
        vecs[4] = '{32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd12,
                    32'h0, 32'hCAFEBABE, 1'b0, 32'h0, 32'd2};

        modelReset();
        rst = 1'b0;
        applyStimulus(32'h13572468, 32'h0, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        checkOutput("reset_we", {31'h0, wb_we}, 32'h0);
        checkOutput("reset_count", wb_count, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            checkOutput($sformatf("reset_rs1[%0d]", i), rs1_data, 32'h0);
            checkOutput($sformatf("reset_rs2[%0d]", 31 - i), rs2_data, 32'h0);
        end

        // Writes presented on edges while reset is low must be dropped.
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        applyStimulus(32'h13572468, 32'h0, 5'd3, 1'b0, 1'b1, 5'd3, 5'd3);
        checkOutput("reset_edge_ignored", rs1_data, 32'h0);
        checkOutput("reset_edge_count", wb_count, 32'h0);
        applyStimulus(32'h13572468, 32'h0, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
        tickEdge();
        applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0);
        checkOutput("first_write_rs1", rs1_data, 32'h13572468);
        checkOutput("first_write_count", wb_count, 32'd1);

        rst = 1'b0;
        #1;
        modelReset();
        rst = 1'b1;
        #1;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].readData, vecs[v].aluResult, vecs[v].rd, vecs[v].regWrite,
                          vecs[v].memToReg, vecs[v].rs1, vecs[v].rs2);
            checkOutput($sformatf("vec%0d_rs1", v), rs1_data, vecs[v].expRs1);
            checkOutput($sformatf("vec%0d_rs2", v), rs2_data, vecs[v].expRs2);
            checkOutput($sformatf("vec%0d_we", v), {31'h0, wb_we}, {31'h0, vecs[v].expWe});
            checkOutput($sformatf("vec%0d_data", v), wb_data, vecs[v].expData);
            checkOutput($sformatf("vec%0d_rd", v), {27'h0, wb_rd}, {27'h0, vecs[v].rd});
            checkOutput($sformatf("vec%0d_count", v), wb_count, vecs[v].expCount);
            tickEdge();
        end

        applyStimulus(32'h0, 32'h11111111, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        tickEdge();
        applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7);
        checkOutput("midop_before_rs1", rs1_data, 32'h11111111);
        rst = 1'b0;
        #1;
        checkOutput("midop_rs1", rs1_data, 32'h0);
        checkOutput("midop_rs2", rs2_data, 32'h0);
        checkOutput("midop_count", wb_count, 32'h0);
        modelReset();
        rst = 1'b1;
        #1;
        checkOutput("midop_after_release", rs1_data, 32'h0);

        force dut.count_q = 32'hFFFFFFFE;
        #1;
        release dut.count_q;
        mCount = 32'hFFFFFFFE;
        applyStimulus(32'h0, 32'h00000009, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
        checkOutput("wrap_preset", wb_count, 32'hFFFFFFFE);
        tickEdge();
        checkOutput("wrap_first", wb_count, 32'hFFFFFFFF);
        tickEdge();
        checkOutput("wrap_second", wb_count, 32'h00000000);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            logic [4:0] a1;
            logic [4:0] a2;
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            applyStimulus($urandom, $urandom, rd, ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), a1, a2);
            checkOutput("rand_rs1", rs1_data, modelRead(rs1_addr));
            checkOutput("rand_rs2", rs2_data, modelRead(rs2_addr));
            checkOutput("rand_we", {31'h0, wb_we}, {31'h0, modelWe()});
            checkOutput("rand_rd", {27'h0, wb_rd}, {27'h0, rd_in});
            checkOutput("rand_data", wb_data, modelWbData());
            checkOutput("rand_count", wb_count, mCount);
            tickEdge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
